ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The module SHALL have parameter SPI_PAGE, default 8'h00: the value of spi_addr[31:24] that selects main RAM.
REQ-002 The module SHALL have parameter CPU_GAP, default 2: the minimum number of IDLE cycles between two SPI grants (range 1-15).
REQ-003 The module SHALL have the following ports:
- clk  in  1  system clock (CPU domain)
- reset_n  in  1  asynchronous, active-low reset
- cpu_mreq  in  1  CPU memory request, RAM selected
- cpu_we  in  1  CPU write qualifier
- cpu_addr  in  16  CPU address
- cpu_din  in  8  CPU write data
- cpu_wait_n  out  1  wait to CPU; low = stall
- spi_wr  in  1  SPI write strobe, 1 cycle
- spi_rd  in  1  SPI read strobe, 1 cycle
- spi_addr  in  32  SPI byte address
- spi_din  in  8  SPI write data
- spi_dout  out  8  SPI read data, registered
- spi_rvalid  out  1  1-cycle pulse, spi_dout valid
- spi_ovf  out  1  sticky overflow flag
- ram_we  out  1  RAM port A write enable
- ram_addr  out  16  RAM port A address
- ram_din  out  8  RAM port A write data
- ram_dout  in  8  RAM port A read data, 1-cycle synchronous latency

Function
REQ-004 Capture: a strobe SHALL be accepted only when spi_addr[31:24]==SPI_PAGE. An accepted strobe SHALL be pushed into a 2-entry FIFO of {type, spi_addr[15:0], spi_din}.
REQ-005 When spi_wr and spi_rd are asserted together, the strobe SHALL be treated as a write.
REQ-006 A strobe that arrives while the FIFO is full (2 entries) with no pop in the same cycle SHALL be dropped, and spi_ovf SHALL be set and held until reset.
REQ-007 A push and a pop in the same cycle SHALL both take effect. The occupancy stays unchanged, and a push into a full FIFO with a simultaneous pop SHALL be accepted.
REQ-008 The FSM SHALL have the states IDLE, SPI_ACC and SPI_RD.
REQ-009 IDLE: ram_addr=cpu_addr, ram_din=cpu_din, ram_we=cpu_mreq&cpu_we. A gap counter SHALL increment, saturating at CPU_GAP.
REQ-010 IDLE->SPI_ACC SHALL occur when the FIFO is non-empty and the gap counter equals CPU_GAP.
REQ-011 SPI_ACC: the head entry SHALL drive ram_addr and ram_din, ram_we=1 for a write entry, and the head SHALL be popped.
REQ-012 From SPI_ACC the FSM SHALL go to SPI_RD for a read entry; otherwise it SHALL return to IDLE and clear the gap counter.
REQ-013 SPI_RD: ram_addr SHALL be held, ram_we=0, spi_dout<=ram_dout (registered), spi_rvalid SHALL pulse in the next cycle, and the FSM SHALL go to IDLE and clear the gap counter.
REQ-014 Read latency SHALL be 3 cycles from strobe to spi_rvalid when the FIFO is empty and the gap counter is saturated. A write SHALL reach RAM in the cycle after the strobe under the same conditions.
REQ-015 cpu_wait_n SHALL be 0 in SPI_ACC and SPI_RD, and in IDLE whenever the FIFO is non-empty. Otherwise it SHALL be 1.
REQ-016 CPU writes SHALL never be issued in SPI states. The CPU holds the bus while stalled and its write completes after return to IDLE.
REQ-017 CPU_GAP SHALL guarantee CPU ownership for at least CPU_GAP cycles between SPI accesses, so a continuous SPI stream cannot starve the CPU.
REQ-018 Address bits 31:16 other than the page byte SHALL be ignored, and address arithmetic SHALL be 16-bit with no wrap logic needed.

Reset
REQ-019 While reset_n=0, asynchronously: FSM=IDLE, FIFO empty, gap counter=CPU_GAP, spi_ovf=0, spi_rvalid=0, spi_dout=8'h00, cpu_wait_n=1, ram_we=0.
REQ-020 Reset asserted mid-access SHALL abort the access: pending entries are discarded and no spi_rvalid is issued.
REQ-021 After reset release, the first SPI request SHALL be grantable immediately.

Verification
REQ-022 SPI write 0x1234<-0xA5 from idle -> ram_we=1, addr 0x1234, din 0xA5 one cycle later; cpu_wait_n low for 2 cycles.
REQ-023 RAM preloaded 0x0100=0x5A, SPI read 0x00000100 -> spi_rvalid pulses at cycle 3 with spi_dout=0x5A; no ram_we.
REQ-024 Three back-to-back SPI writes with CPU_GAP=2 -> grants separated by 2 IDLE cycles; no drop; spi_ovf stays 0.
REQ-025 Strobes on every cycle with spi_addr[31:24]=0xFF -> none accepted, ram_we stays driven by the CPU only.
REQ-026 Fill the FIFO, then a third strobe with no pop -> third strobe dropped, spi_ovf=1, and it remains 1 until reset_n pulses low.
REQ-027 reset_n low during SPI_RD -> outputs reach reset values immediately; no spi_rvalid after release.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between the CPU and a byte-wide SPI
// bridge. SPI strobes are queued in a 2-entry FIFO. They are granted only
// after the CPU has owned the port for CPU_GAP idle cycles, so a continuous
// SPI stream can never starve the CPU.
module ram_port_arbiter #(
    parameter logic [7:0]  SPI_PAGE = 8'h00,
    parameter int unsigned CPU_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_mreq,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    input  logic        spi_wr,
    input  logic        spi_rd,
    input  logic [31:0] spi_addr,
    input  logic [7:0]  spi_din,
    output logic [7:0]  spi_dout,
    output logic        spi_rvalid,
    output logic        spi_ovf,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPI_ACC = 2'd1,
        SPI_RD  = 2'd2
    } state_t;

    typedef struct packed {
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    localparam logic [3:0] GAP_MAX = 4'(CPU_GAP);

    state_t      state;
    state_t      state_next;
    entry_t      fifo_mem [2];
    entry_t      head;
    entry_t      push_entry;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_cnt;
    logic        strobe_hit;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        drop;
    logic        pending;
    logic [3:0]  gap_cnt;
    logic [3:0]  gap_inc;
    logic        gap_done;
    logic [15:0] hold_addr;
    logic        unused_addr_bits;

    // Only the page byte qualifies a strobe; bits 23:16 carry no meaning here.
    assign unused_addr_bits = ^spi_addr[23:16];

    // A strobe is gated by reset_n, so nothing reaches the outputs while reset is held.
    // A combined wr+rd strobe is stored as a write.
    assign strobe_hit = reset_n & (spi_wr | spi_rd) & (spi_addr[31:24] == SPI_PAGE);
    assign push_entry = '{is_wr: spi_wr, addr: spi_addr[15:0], data: spi_din};

    assign fifo_full = (fifo_cnt == 2'd2);
    assign pop       = (state == SPI_ACC);
    assign push      = strobe_hit & (~fifo_full | pop);
    assign drop      = strobe_hit & fifo_full & ~pop;
    assign head      = fifo_mem[rd_ptr];

    // A strobe arriving this cycle already counts as queued work. This lets an
    // idle, saturated arbiter grant it at the very next edge.
    assign pending = (fifo_cnt != 2'd0) | push;

    // gap_inc is the number of CPU-owned idle cycles including the current one.
    // A grant waits until CPU_GAP such cycles have elapsed.
    assign gap_inc  = (gap_cnt >= GAP_MAX) ? GAP_MAX : gap_cnt + 4'd1;
    assign gap_done = (gap_inc == GAP_MAX);

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are only ever read behind a valid occupancy count.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; fifo_cnt alone decides what is valid.
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    // Sticky overflow: set by any strobe dropped on a full FIFO, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  spi_ovf <= 1'b0;
        else if (drop) spi_ovf <= 1'b1;
    end

    // Gap counter: counts up in IDLE and restarts at zero when an SPI access completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 gap_cnt <= GAP_MAX;
        else if (state == IDLE)       gap_cnt <= gap_inc;
        else if (state_next == IDLE)  gap_cnt <= 4'd0;
    end

    // Hold the read address so RAM still sees it in SPI_RD after the head is popped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               hold_addr <= 16'h0000;
        else if (state == SPI_ACC)  hold_addr <= head.addr;
    end

    // Capture read data in SPI_RD, then present it with a one-cycle valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_dout   <= 8'h00;
            spi_rvalid <= 1'b0;
        end else begin
            spi_rvalid <= (state == SPI_RD);
            if (state == SPI_RD) spi_dout <= ram_dout;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FSM next state: grant queued work only once the CPU has had its gap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (pending && gap_done) state_next = SPI_ACC;
            SPI_ACC: state_next = head.is_wr ? IDLE : SPI_RD;
            SPI_RD:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: the CPU owns the RAM port in IDLE; the FIFO head owns it in SPI states.
    always_comb begin
        cpu_wait_n = 1'b1;
        ram_we     = 1'b0;
        ram_addr   = cpu_addr;
        ram_din    = cpu_din;
        case (state)
            IDLE: begin
                ram_we     = cpu_mreq & cpu_we & reset_n;
                cpu_wait_n = ~pending;
            end
            SPI_ACC: begin
                ram_addr   = head.addr;
                ram_din    = head.data;
                ram_we     = head.is_wr;
                cpu_wait_n = 1'b0;
            end
            SPI_RD: begin
                ram_addr   = hold_addr;
                ram_din    = 8'h00;
                cpu_wait_n = 1'b0;
            end
            default: begin
                cpu_wait_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with default
// parameters (SPI_PAGE=8'h00, CPU_GAP=2). Inputs change on the falling
// edge. Outputs are sampled 1 ns later, so each step shows the cycle
// that the next rising edge will act on.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mreq;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_wait_n;
    logic        spi_wr;
    logic        spi_rd;
    logic [31:0] spi_addr;
    logic [7:0]  spi_din;
    logic [7:0]  spi_dout;
    logic        spi_rvalid;
    logic        spi_ovf;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_mreq   (cpu_mreq),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_wait_n (cpu_wait_n),
        .spi_wr     (spi_wr),
        .spi_rd     (spi_rd),
        .spi_addr   (spi_addr),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .spi_rvalid (spi_rvalid),
        .spi_ovf    (spi_ovf),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Synchronous RAM model with one cycle of read latency.
    logic [7:0] ram_mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of SPI inputs at the falling edge, then settle.
    task automatic step(input logic wr, input logic rd, input logic [31:0] addr, input logic [7:0] din);
        @(negedge clk);
        spi_wr   = wr;
        spi_rd   = rd;
        spi_addr = addr;
        spi_din  = din;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic cpu_set(input logic mreq, input logic we, input logic [15:0] addr, input logic [7:0] din);
        cpu_mreq = mreq;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
    endtask

    // Back-to-back SPI writes starting from a saturated gap. Grants land on
    // cycles 1, 4 and 7. With 4 strobes, the 4th (cycle 3) meets a full FIFO
    // with no pop, is dropped and sets spi_ovf from cycle 4.
    task automatic run_burst(input int n, input logic [15:0] base);
        logic [7:0]  data;
        logic [15:0] a;
        for (int c = 0; c < 10; c++) begin
            a    = base + 16'(c);
            data = 8'(8'h11 * (c + 1));
            if (c < n) step(1'b1, 1'b0, {16'h0000, a}, data);
            else       step(1'b0, 1'b0, 32'h0, 8'h00);
            check($sformatf("burst%0d_we_c%0d", n, c), ram_we, (c == 1 || c == 4 || c == 7));
            check($sformatf("burst%0d_wait_c%0d", n, c), cpu_wait_n, (c >= 8));
            check($sformatf("burst%0d_ovf_c%0d", n, c), spi_ovf, (n == 4 && c >= 4));
            if (c == 1 || c == 4 || c == 7) begin
                a    = base + 16'((c - 1) / 3);
                data = 8'(8'h11 * ((c - 1) / 3 + 1));
                check($sformatf("burst%0d_addr_c%0d", n, c), ram_addr, a);
                check($sformatf("burst%0d_din_c%0d", n, c), ram_din, data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset values, with a write CPU request and a valid strobe pushing against them.
        reset_n = 1'b0;
        cpu_set(1'b1, 1'b1, 16'h0010, 8'hEE);
        spi_wr = 1'b1; spi_rd = 1'b0; spi_addr = 32'h0000_0008; spi_din = 8'h99;
        #2;
        check("rst_wait_n", cpu_wait_n, 1'b1);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_rvalid", spi_rvalid, 1'b0);
        check("rst_dout", spi_dout, 8'h00);
        check("rst_ovf", spi_ovf, 1'b0);
        cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        spi_wr = 1'b0;
        reset_n = 1'b1;
        idle(1);
        check("post_rst_wait_n", cpu_wait_n, 1'b1);

        // Single SPI write 0x1234 <- 0xA5 is granted immediately after reset.
        step(1'b1, 1'b0, 32'h0000_1234, 8'hA5);
        check("wr_c0_wait_n", cpu_wait_n, 1'b0);
        check("wr_c0_ram_we", ram_we, 1'b0);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("wr_c1_ram_we", ram_we, 1'b1);
        check("wr_c1_addr", ram_addr, 16'h1234);
        check("wr_c1_din", ram_din, 8'hA5);
        check("wr_c1_wait_n", cpu_wait_n, 1'b0);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("wr_c2_wait_n", cpu_wait_n, 1'b1);
        check("wr_c2_ram_we", ram_we, 1'b0);
        idle(3);

        // CPU preloads 0x0100 = 0x5A through the shared port.
        cpu_set(1'b1, 1'b1, 16'h0100, 8'h5A);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("cpu_wr_we", ram_we, 1'b1);
        check("cpu_wr_addr", ram_addr, 16'h0100);
        cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);

        // SPI read of 0x00000100: spi_rvalid is expected on cycle 3 with 0x5A.
        step(1'b0, 1'b1, 32'h0000_0100, 8'h00);
        check("rd_c0_wait_n", cpu_wait_n, 1'b0);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("rd_c1_addr", ram_addr, 16'h0100);
        check("rd_c1_we", ram_we, 1'b0);
        check("rd_c1_rvalid", spi_rvalid, 1'b0);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("rd_c2_addr", ram_addr, 16'h0100);
        check("rd_c2_we", ram_we, 1'b0);
        check("rd_c2_wait_n", cpu_wait_n, 1'b0);
        check("rd_c2_rvalid", spi_rvalid, 1'b0);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("rd_c3_rvalid", spi_rvalid, 1'b1);
        check("rd_c3_dout", spi_dout, 8'h5A);
        check("rd_c3_wait_n", cpu_wait_n, 1'b1);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("rd_c4_rvalid", spi_rvalid, 1'b0);
        idle(3);

        // A combined wr+rd strobe is handled as a write: no read phase and no rvalid.
        step(1'b1, 1'b1, 32'h0000_0200, 8'h3C);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("wrrd_c1_we", ram_we, 1'b1);
        check("wrrd_c1_din", ram_din, 8'h3C);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("wrrd_c2_wait_n", cpu_wait_n, 1'b1);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("wrrd_c3_rvalid", spi_rvalid, 1'b0);
        idle(3);

        // A stalled CPU write is held off during SPI_ACC and resumes in IDLE.
        cpu_set(1'b1, 1'b1, 16'h0500, 8'h77);
        step(1'b1, 1'b0, 32'h0000_0020, 8'hC3);
        check("stall_c0_wait_n", cpu_wait_n, 1'b0);
        check("stall_c0_addr", ram_addr, 16'h0500);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("stall_c1_addr", ram_addr, 16'h0020);
        check("stall_c1_din", ram_din, 8'hC3);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("stall_c2_addr", ram_addr, 16'h0500);
        check("stall_c2_we", ram_we, 1'b1);
        check("stall_c2_wait_n", cpu_wait_n, 1'b1);
        cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
        idle(3);

        // Three back-to-back writes: spaced grants, no drop, no overflow.
        run_burst(3, 16'h0010);
        idle(3);

        // Strobes outside the page are ignored; the CPU keeps the port.
        for (int c = 0; c < 6; c++) begin
            step(1'b1, c[0], 32'hFF00_0040 + 32'(c), 8'h5F);
            check($sformatf("page_we_c%0d", c), ram_we, 1'b0);
            check($sformatf("page_wait_c%0d", c), cpu_wait_n, 1'b1);
        end
        idle(2);
        check("page_ovf", spi_ovf, 1'b0);

        // Four back-to-back writes: the fourth is dropped and spi_ovf becomes sticky.
        run_burst(4, 16'h0030);
        idle(6);
        check("ovf_sticky", spi_ovf, 1'b1);

        // Reset asserted during SPI_RD aborts the read and clears the overflow flag.
        step(1'b0, 1'b1, 32'h0000_0100, 8'h00);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("abort_c1_addr", ram_addr, 16'h0100);
        cpu_set(1'b1, 1'b1, 16'h0600, 8'h12);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("abort_c2_in_rd_wait_n", cpu_wait_n, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_rst_wait_n", cpu_wait_n, 1'b1);
        check("abort_rst_we", ram_we, 1'b0);
        check("abort_rst_rvalid", spi_rvalid, 1'b0);
        check("abort_rst_dout", spi_dout, 8'h00);
        check("abort_rst_ovf", spi_ovf, 1'b0);
        cpu_set(1'b0, 1'b0, 16'h0000, 8'h00);
        idle(1);

        // The first request after release is granted at once; address bits 23:16 are ignored.
        @(negedge clk);
        reset_n  = 1'b1;
        spi_wr   = 1'b1;
        spi_rd   = 1'b0;
        spi_addr = 32'h00AB_0040;
        spi_din  = 8'h6B;
        #1;
        check("rel_c0_wait_n", cpu_wait_n, 1'b0);
        step(1'b0, 1'b0, 32'h0, 8'h00);
        check("rel_c1_we", ram_we, 1'b1);
        check("rel_c1_addr", ram_addr, 16'h0040);
        check("rel_c1_din", ram_din, 8'h6B);
        for (int c = 2; c < 6; c++) begin
            step(1'b0, 1'b0, 32'h0, 8'h00);
            check($sformatf("rel_rvalid_c%0d", c), spi_rvalid, 1'b0);
        end
        check("rel_ovf", spi_ovf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
